dpr_rr_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters, A and B.
- Arbitration is round-robin, with an optional grant lock for back-to-back bursts.
- The RAM array is inside the block. Each requester sees a req/gnt handshake and a 1-cycle read-response channel.
- Sits between two clients that would otherwise each need a port of a true dual-port RAM; trades throughput for one port and one clock domain.

---
 rtl/dpr_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_dpr_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dpr_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one internal single-port RAM.
// Each requester gets a combinational req/gnt handshake and a registered 1-cycle read response.
module dpr_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_q,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  req_id_e               last_owner_q, last_owner_d;
  req_id_e               owner_q, owner_d;
  logic                  locked_q, locked_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  logic                  a_acc, b_acc;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // While locked, the non-owner is held off even if the owner goes idle.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (locked_q) begin
      if (owner_q == REQ_A) a_gnt = a_req;
      else                  b_gnt = b_req;
    end else if (a_req && !b_req) begin
      a_gnt = 1'b1;
    end else if (b_req && !a_req) begin
      b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      if (last_owner_q == REQ_B) a_gnt = 1'b1;
      else                       b_gnt = 1'b1;
    end
  end

  assign a_acc = a_req & a_gnt;
  assign b_acc = b_req & b_gnt;

  // A cycle without an accepted command always drops the lock.
  always_comb begin
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    locked_d     = 1'b0;
    if (a_acc) begin
      last_owner_d = REQ_A;
      owner_d      = REQ_A;
      locked_d     = a_lock;
    end else if (b_acc) begin
      last_owner_d = REQ_B;
      owner_d      = REQ_B;
      locked_d     = b_lock;
    end
  end

  always_comb begin
    a_rvalid_d = a_acc & ~a_we;
    b_rvalid_d = b_acc & ~b_we;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (a_rvalid_d) a_rdata_d = mem[a_addr];
    if (b_rvalid_d) b_rdata_d = mem[b_addr];
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = a_addr;
    wr_data = a_data;
    if (a_acc && a_we) begin
      wr_en = 1'b1;
    end else if (b_acc && b_we) begin
      wr_en   = 1'b1;
      wr_addr = b_addr;
      wr_data = b_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= REQ_B;
      owner_q      <= REQ_A;
      locked_q     <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      locked_q     <= locked_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_q      = a_rdata_q;
  assign b_q      = b_rdata_q;

endmodule

// File: tb/tb_dpr_rr_arbiter.sv
// Directed bench for dpr_rr_arbiter: handshake, round-robin order, locking,
// cross-requester data visibility and asynchronous reset.
module tb_dpr_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       a_req, a_we, a_lock;
  logic [7:0] a_addr, a_data;
  logic       a_gnt, a_rvalid;
  logic [7:0] a_q;
  logic       b_req, b_we, b_lock;
  logic [7:0] b_addr, b_data;
  logic       b_gnt, b_rvalid;
  logic [7:0] b_q;

  int nchk = 0;
  int nerr = 0;

  dpr_rr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_data(a_data),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_q(a_q),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_data(b_data),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_q(b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] data);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_data = data;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] data);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gnts(input string tag, input logic ea, input logic eb);
    #1;
    chk({tag, "_a_gnt"}, {31'b0, a_gnt}, {31'b0, ea});
    chk({tag, "_b_gnt"}, {31'b0, b_gnt}, {31'b0, eb});
  endtask

  initial begin
    rst = 1'b1;
    drv_a(0, 0, 0, 8'h00, 8'h00);
    drv_b(0, 0, 0, 8'h00, 8'h00);
    #1 rst = 1'b0;
    #10;
    chk("rst_a_rvalid", {31'b0, a_rvalid}, 0);
    chk("rst_b_rvalid", {31'b0, b_rvalid}, 0);
    chk("rst_a_q", {24'b0, a_q}, 0);
    chk("rst_b_q", {24'b0, b_q}, 0);
    #1 rst = 1'b1;
    tick();

    // Basic write then read from A
    drv_a(1, 1, 0, 8'h10, 8'h5A);
    gnts("wr10", 1, 0);
    tick();
    chk("wr10_no_rvalid", {31'b0, a_rvalid}, 0);
    drv_a(1, 0, 0, 8'h10, 8'h00);
    gnts("rd10", 1, 0);
    tick();
    chk("rd10_a_rvalid", {31'b0, a_rvalid}, 1);
    chk("rd10_a_q", {24'b0, a_q}, 8'h5A);
    chk("rd10_b_rvalid", {31'b0, b_rvalid}, 0);
    drv_a(0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("idle_a_rvalid", {31'b0, a_rvalid}, 0);
    chk("hold_a_q", {24'b0, a_q}, 8'h5A);

    // Preload 0x01/0x02, then reset so the contest starts fresh
    drv_a(1, 1, 0, 8'h01, 8'h11);
    tick();
    drv_a(0, 0, 0, 8'h00, 8'h00);
    drv_b(1, 1, 0, 8'h02, 8'h22);
    tick();
    drv_b(0, 0, 0, 8'h00, 8'h00);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();

    drv_a(1, 0, 0, 8'h01, 8'h00);
    drv_b(1, 0, 0, 8'h02, 8'h00);
    for (int i = 0; i < 4; i++) begin
      logic ea;
      ea = (i % 2 == 0);
      #1;
      chk($sformatf("rr%0d_a_gnt", i), {31'b0, a_gnt}, {31'b0, ea});
      chk($sformatf("rr%0d_b_gnt", i), {31'b0, b_gnt}, {31'b0, ~ea});
      chk($sformatf("rr%0d_one_hot", i), {31'b0, a_gnt & b_gnt}, 0);
      tick();
      chk($sformatf("rr%0d_a_rvalid", i), {31'b0, a_rvalid}, {31'b0, ea});
      chk($sformatf("rr%0d_b_rvalid", i), {31'b0, b_rvalid}, {31'b0, ~ea});
      if (ea) chk($sformatf("rr%0d_a_q", i), {24'b0, a_q}, 8'h11);
      else    chk($sformatf("rr%0d_b_q", i), {24'b0, b_q}, 8'h22);
    end

    // Lock burst: A holds the RAM for three writes while B waits
    drv_b(1, 0, 0, 8'h10, 8'h00);
    for (int k = 0; k < 3; k++) begin
      drv_a(1, 1, (k < 2), 8'h20 + 8'(k), 8'hA0 + 8'(k));
      gnts($sformatf("lock%0d", k), 1, 0);
      tick();
    end
    drv_a(1, 0, 0, 8'h21, 8'h00);
    gnts("after_lock", 0, 1);
    tick();
    chk("after_lock_b_rvalid", {31'b0, b_rvalid}, 1);
    chk("after_lock_b_q", {24'b0, b_q}, 8'h5A);
    drv_b(0, 0, 0, 8'h00, 8'h00);
    gnts("rd21", 1, 0);
    tick();
    chk("rd21_a_q", {24'b0, a_q}, 8'hA1);
    chk("rd21_b_rvalid", {31'b0, b_rvalid}, 0);

    // Lock released by an idle owner cycle
    drv_a(1, 1, 1, 8'h23, 8'hA3);
    gnts("idle_lock_wr", 1, 0);
    tick();
    drv_a(0, 0, 0, 8'h00, 8'h00);
    drv_b(1, 0, 0, 8'h23, 8'h00);
    gnts("idle_lock_gap", 0, 0);
    tick();
    chk("idle_gap_b_rvalid", {31'b0, b_rvalid}, 0);
    gnts("idle_lock_rel", 0, 1);
    tick();
    chk("idle_rel_b_q", {24'b0, b_q}, 8'hA3);

    // B writes, A reads the same address on the next cycle
    drv_b(1, 1, 0, 8'h40, 8'h33);
    gnts("xwr40", 0, 1);
    tick();
    drv_b(0, 0, 0, 8'h00, 8'h00);
    drv_a(1, 0, 0, 8'h40, 8'h00);
    gnts("xrd40", 1, 0);
    tick();
    chk("xrd40_a_rvalid", {31'b0, a_rvalid}, 1);
    chk("xrd40_a_q", {24'b0, a_q}, 8'h33);

    // Reset asserted between edges during a locked read burst
    drv_a(1, 0, 1, 8'h40, 8'h00);
    tick();
    chk("burst_a_rvalid", {31'b0, a_rvalid}, 1);
    drv_b(1, 0, 0, 8'h40, 8'h00);
    gnts("burst_locked", 1, 0);
    #1 rst = 1'b0;
    #1;
    chk("arst_a_rvalid", {31'b0, a_rvalid}, 0);
    chk("arst_a_q", {24'b0, a_q}, 0);
    #2 rst = 1'b1;
    drv_a(1, 0, 0, 8'h21, 8'h00);
    gnts("post_rst", 1, 0);
    tick();
    chk("post_rst_a_q", {24'b0, a_q}, 8'hA1);
    gnts("post_rst2", 0, 1);
    tick();
    chk("post_rst_b_q", {24'b0, b_q}, 8'h33);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
